// File: rtl/byp_seq.sv
// Bypass-switch sequencer: blocks the IGBT gates, closes the mechanical bypass,
// retries on missing feedback and latches DONE/FAIL until a hard reset.
module byp_seq #(
  parameter int unsigned FIBER_DLY_US = 1000,
  parameter int unsigned GATE_OFF_US  = 20,
  parameter int unsigned CONFIRM_US   = 5000,
  parameter int unsigned RETRY_GAP_US = 500,
  parameter int unsigned MAX_RETRY    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       time_1us,
  input  logic       reset_unit,
  input  logic       byp_cmd_rx,
  input  logic       fiber_err,
  input  logic       unit_fault,
  input  logic       byp_ok,
  output logic       pwm_block,
  output logic       byp_con,
  output logic       byp_fail,
  output logic [1:0] byp_src,
  output logic [2:0] byp_state
);

  localparam logic [15:0] FIBER_LIM     = 16'(FIBER_DLY_US);
  localparam logic [15:0] GATE_LIM      = 16'(GATE_OFF_US);
  localparam logic [15:0] CONFIRM_LIM   = 16'(CONFIRM_US);
  localparam logic [15:0] GAP_LIM       = 16'(RETRY_GAP_US);
  localparam logic [15:0] DONE_LOSS_LIM = 16'd1000;
  localparam logic [1:0]  RETRY_LIM     = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BLOCK = 3'd1,
    S_CLOSE = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] tick_cnt, tick_d;
  logic [15:0] fiber_cnt;
  logic [1:0]  retry_cnt, retry_d;
  logic [1:0]  src_d;
  logic        fiber_trig;

  // Continuous fiber-fault timer, saturating at the trigger value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fiber_cnt <= '0;
    end else if (!fiber_err || reset_unit) begin
      fiber_cnt <= '0;
    end else if (time_1us && (fiber_cnt < FIBER_LIM)) begin
      fiber_cnt <= fiber_cnt + 16'd1;
    end
  end

  assign fiber_trig = (fiber_cnt == FIBER_LIM);

  always_comb begin
    state_d = state_q;
    retry_d = retry_cnt;
    src_d   = byp_src;
    case (state_q)
      S_IDLE: begin
        retry_d = '0;
        if (unit_fault) begin
          state_d = S_BLOCK;
          src_d   = 2'b11;
        end else if (fiber_trig) begin
          state_d = S_BLOCK;
          src_d   = 2'b10;
        end else if (byp_cmd_rx && !fiber_err) begin
          state_d = S_BLOCK;
          src_d   = 2'b01;
        end else if (byp_ok) begin
          state_d = S_DONE;
          src_d   = 2'b00;
        end
      end
      S_BLOCK: begin
        if (tick_cnt >= GATE_LIM) state_d = S_CLOSE;
      end
      S_CLOSE: begin
        if (byp_ok) begin
          state_d = S_DONE;
        end else if (tick_cnt >= CONFIRM_LIM) begin
          if (retry_cnt < RETRY_LIM) begin
            state_d = S_GAP;
            retry_d = retry_cnt + 2'd1;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_GAP: begin
        if (byp_ok) state_d = S_DONE;
        else if (tick_cnt >= GAP_LIM) state_d = S_CLOSE;
      end
      S_DONE: begin
        if (tick_cnt >= DONE_LOSS_LIM) state_d = S_FAIL;
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_IDLE;
        retry_d = '0;
      end
    endcase
  end

  // A tick on the transition clock belongs to the new state; in DONE the
  // counter measures consecutive ticks without bypass feedback.
  always_comb begin
    tick_d = tick_cnt;
    if (state_d != state_q) begin
      tick_d = {15'd0, time_1us};
    end else if (state_q == S_IDLE) begin
      tick_d = '0;
    end else if ((state_q == S_DONE) && byp_ok) begin
      tick_d = '0;
    end else if (time_1us && (tick_cnt != 16'hFFFF)) begin
      tick_d = tick_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tick_cnt  <= '0;
      retry_cnt <= '0;
      byp_src   <= 2'b00;
      pwm_block <= 1'b0;
      byp_con   <= 1'b0;
      byp_fail  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_cnt  <= tick_d;
      retry_cnt <= retry_d;
      byp_src   <= src_d;
      pwm_block <= (state_d != S_IDLE);
      byp_con   <= (state_d == S_CLOSE) || (state_d == S_DONE) || (state_d == S_FAIL);
      byp_fail  <= (state_d == S_FAIL);
    end
  end

  assign byp_state = state_q;

endmodule

// File: tb/tb_byp_seq.sv
// Bench for byp_seq: trigger table, directed multi-cycle sequences and a
// randomized run checked every clock against a behavioural model.
`timescale 1ns/1ps
module tb_byp_seq;

  localparam int F = 10;
  localparam int G = 3;
  localparam int C = 20;
  localparam int R = 5;
  localparam int M = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       time_1us;
  logic       reset_unit;
  logic       byp_cmd_rx;
  logic       fiber_err;
  logic       unit_fault;
  logic       byp_ok;
  logic       pwm_block;
  logic       byp_con;
  logic       byp_fail;
  logic [1:0] byp_src;
  logic [2:0] byp_state;

  always #12.5 clk = ~clk;

  byp_seq #(
    .FIBER_DLY_US(F), .GATE_OFF_US(G), .CONFIRM_US(C),
    .RETRY_GAP_US(R), .MAX_RETRY(M)
  ) dut (
    .clk(clk), .rst_n(rst_n), .time_1us(time_1us), .reset_unit(reset_unit),
    .byp_cmd_rx(byp_cmd_rx), .fiber_err(fiber_err), .unit_fault(unit_fault),
    .byp_ok(byp_ok), .pwm_block(pwm_block), .byp_con(byp_con),
    .byp_fail(byp_fail), .byp_src(byp_src), .byp_state(byp_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tick_period;
  int tick_phase;
  int ticks_driven;

  // Model: which state we are in, how many ticks have elapsed there, how many
  // retries were spent, how long the fiber has been continuously bad.
  int m_state, m_ticks, m_retry, m_fib, m_src;

  int         vis_ticks[$];
  logic [2:0] vis_state[$];
  logic [2:0] exp_q[$];

  typedef struct {
    int         prime;
    logic       uf, fe, cmd, ok;
    logic [2:0] exp_state;
    logic [1:0] exp_src;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [2:0] s;
    logic [1:0] src;
    s   = 3'(m_state);
    src = 2'(m_src);
    return {(m_state != 0), (m_state == 2 || m_state == 4 || m_state == 5),
            (m_state == 5), src, s};
  endfunction

  task automatic model_reset();
    m_state = 0; m_ticks = 0; m_retry = 0; m_fib = 0; m_src = 0;
  endtask

  task automatic model_step(input logic uf, fe, cmd, ok, ru, tk);
    int  ns;
    bit  trig;
    trig = (m_fib == F);
    ns   = m_state;
    case (m_state)
      0: begin
        m_retry = 0;
        if (uf)              begin ns = 1; m_src = 3; end
        else if (trig)       begin ns = 1; m_src = 2; end
        else if (cmd && !fe) begin ns = 1; m_src = 1; end
        else if (ok)         begin ns = 4; m_src = 0; end
      end
      1: if (m_ticks >= G) ns = 2;
      2: begin
        if (ok) ns = 4;
        else if (m_ticks >= C) begin
          if (m_retry < M) begin m_retry++; ns = 3; end
          else ns = 5;
        end
      end
      3: begin
        if (ok) ns = 4;
        else if (m_ticks >= R) ns = 2;
      end
      4: if (m_ticks >= 1000) ns = 5;
      default: ;
    endcase
    if (ns != m_state)           m_ticks = int'(tk);
    else if (m_state == 0)       m_ticks = 0;
    else if (m_state == 4 && ok) m_ticks = 0;
    else                         m_ticks += int'(tk);
    if (!fe || ru)          m_fib = 0;
    else if (tk && m_fib < F) m_fib++;
    m_state = ns;
  endtask

  // Called at a falling edge: check, drive one clock of inputs, advance model.
  task automatic step(input logic uf, fe, cmd, ok, ru);
    logic tk;
    check("outputs", {pwm_block, byp_con, byp_fail, byp_src, byp_state}, model_out());
    if (vis_state.size() == 0 || vis_state[vis_state.size()-1] != byp_state) begin
      vis_state.push_back(byp_state);
      vis_ticks.push_back(0);
    end
    tk = (tick_phase == tick_period - 1);
    tick_phase = tk ? 0 : tick_phase + 1;
    if (tk) begin
      ticks_driven++;
      vis_ticks[vis_ticks.size()-1] = vis_ticks[vis_ticks.size()-1] + 1;
    end
    time_1us   = tk;
    unit_fault = uf;
    fiber_err  = fe;
    byp_cmd_rx = cmd;
    byp_ok     = ok;
    reset_unit = ru;
    model_step(uf, fe, cmd, ok, ru, tk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int period);
    rst_n = 1'b0;
    time_1us = 1'b0; unit_fault = 1'b0; fiber_err = 1'b0;
    byp_cmd_rx = 1'b0; byp_ok = 1'b0; reset_unit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", {pwm_block, byp_con, byp_fail, byp_src, byp_state}, 8'h00);
    model_reset();
    tick_period  = period;
    tick_phase   = 0;
    ticks_driven = 0;
    vis_state.delete();
    vis_ticks.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, guard;
    logic uf, fe, cmd, ok, ru;

    tbl[0]  = '{0,  1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0};
    tbl[1]  = '{0,  1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 2'd1};
    tbl[2]  = '{0,  1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0};
    tbl[3]  = '{0,  1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 2'd3};
    tbl[4]  = '{0,  1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 2'd0};
    tbl[5]  = '{0,  1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 2'd3};
    tbl[6]  = '{0,  1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 2'd1};
    tbl[7]  = '{F,  1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 2'd2};
    tbl[8]  = '{F,  1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 2'd3};
    tbl[9]  = '{F,  1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 2'd2};
    tbl[10] = '{F-1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0};
    tbl[11] = '{F,  1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 2'd2};

    rst_n = 1'b0;
    tick_period = 40;
    @(negedge clk);

    // Trigger table: optional fiber pre-fault, then one clock of inputs.
    for (int i = 0; i < 12; i++) begin
      do_reset(40);
      guard = 0;
      while (ticks_driven < tbl[i].prime && guard < 2000) begin
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        guard++;
      end
      step(tbl[i].uf, tbl[i].fe, tbl[i].cmd, tbl[i].ok, 1'b0);
      check($sformatf("tbl%0d_state", i), byp_state, tbl[i].exp_state);
      check($sformatf("tbl%0d_src", i), byp_src, tbl[i].exp_src);
    end

    // Command-driven close confirmed on the 8th tick of CLOSE.
    do_reset(40);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("cmd_block_state", byp_state, 3'd1);
    check("cmd_block_pwm", pwm_block, 1'b1);
    check("cmd_block_con", byp_con, 1'b0);
    guard = 0;
    while (byp_state != 3'd2 && guard < 1000) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    check("cmd_close_con", byp_con, 1'b1);
    check("cmd_block_ticks", vis_ticks[1], G);
    t0 = ticks_driven;
    guard = 0;
    while (ticks_driven - t0 < 8 && guard < 1000) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    check("cmd_still_close", byp_state, 3'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("cmd_done_state", byp_state, 3'd4);
    check("cmd_done_src", byp_src, 2'd1);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, k[0], 1'b1, 1'b1);
    check("cmd_done_hold", byp_state, 3'd4);

    // Fiber fault: 9 ticks, one tick clear, then 10 continuous ticks.
    do_reset(40);
    guard = 0;
    while (ticks_driven < 9 && guard < 1000) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    for (int k = 0; k < 40; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fiber9_idle", byp_state, 3'd0);
    t0 = ticks_driven;
    guard = 0;
    while (byp_state == 3'd0 && guard < 2000) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    check("fiber10_state", byp_state, 3'd1);
    check("fiber10_src", byp_src, 2'd2);
    check("fiber10_ticks", ticks_driven - t0, F);

    // No feedback ever: full retry pattern into FAIL, reset_unit toggling.
    do_reset(40);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (byp_state != 3'd5 && guard < 10000) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      guard++;
    end
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("retry_fail_flag", byp_fail, 1'b1);
    check("retry_fail_con", byp_con, 1'b1);
    check("retry_fail_state", byp_state, 3'd5);
    exp_q = {3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 3'd5};
    check("retry_visits", vis_state.size(), exp_q.size());
    if (vis_state.size() == exp_q.size()) begin
      int exp_t[7] = '{0, G, C, R, C, R, C};
      for (int k = 0; k < exp_q.size(); k++)
        check($sformatf("retry_visit%0d_state", k), vis_state[k], exp_q[k]);
      for (int k = 1; k < 7; k++)
        check($sformatf("retry_visit%0d_ticks", k), vis_ticks[k], exp_t[k]);
    end

    // DONE loses feedback: 999 ticks tolerated, 1000 ticks fail.
    do_reset(2);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("done_entry_state", byp_state, 3'd4);
    check("done_entry_src", byp_src, 2'd0);
    t0 = ticks_driven;
    while (ticks_driven - t0 < 999) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("done_999", byp_state, 3'd4);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    t0 = ticks_driven;
    while (ticks_driven - t0 < 1000) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("done_1000_state", byp_state, 3'd5);
    check("done_1000_fail", byp_fail, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("fail_sticky", byp_state, 3'd5);

    // Asynchronous reset while closing.
    do_reset(40);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (byp_state != 3'd2 && guard < 1000) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    check("arst_pre_con", byp_con, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_con", byp_con, 1'b0);
    check("arst_pwm", pwm_block, 1'b0);
    check("arst_state", byp_state, 3'd0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("arst_release_state", byp_state, 3'd0);

    // Randomized levels, checked every clock by the model.
    for (int trial = 0; trial < 20; trial++) begin
      do_reset($urandom_range(1, 6));
      uf = 1'b0; fe = 1'b0; cmd = 1'b0; ok = 1'b0; ru = 1'b0;
      for (int k = 0; k < 600; k++) begin
        uf = ($urandom_range(0, 299) == 0);
        ru = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 24) == 0) fe = ~fe;
        if ($urandom_range(0, 29) == 0) cmd = ~cmd;
        if ($urandom_range(0, 59) == 0) ok = ~ok;
        step(uf, fe, cmd, ok, ru);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byp_seq.md
BYP_SEQ -- requirements
Module: byp_seq

Interface
REQ-001 Parameters (name, default, meaning): FIBER_DLY_US 1000, continuous fiber-fault time that forces bypass; GATE_OFF_US 20, gate-block to bypass-close delay; CONFIRM_US 5000, window for bypass confirmation; RETRY_GAP_US 500, byp_con low time between attempts; MAX_RETRY 2, re-close attempts allowed after the first.
REQ-002 All *_US parameters SHALL be 1..65535 and MAX_RETRY 0..3.
REQ-003 Port: clk, in, 1, system clock (40 MHz).
REQ-004 Port: rst_n, in, 1, asynchronous active-low reset; one clock, reset asynchronous active-low.
REQ-005 Port: time_1us, in, 1, one-clk-wide tick every 1 us.
REQ-006 Port: reset_unit, in, 1, fault-reset command level from the fiber receiver.
REQ-007 Port: byp_cmd_rx, in, 1, bypass command level from the fiber receiver.
REQ-008 Port: fiber_err, in, 1, OR of fiber delay and fiber verify errors.
REQ-009 Port: unit_fault, in, 1, critical local fault (hardware OV or IGBT err) demanding bypass.
REQ-010 Port: byp_ok, in, 1, debounced bypass-closed feedback, active high.
REQ-011 Port: pwm_block, out, 1, forces all four IGBT gates off.
REQ-012 Port: byp_con, out, 1, bypass switch close drive.
REQ-013 Port: byp_fail, out, 1, bypass failed to confirm or opened after confirmation.
REQ-014 Port: byp_src, out, 2, latched cause: 00 spontaneous, 01 command, 10 fiber loss, 11 unit fault.
REQ-015 Port: byp_state, out, 3, current state code.

Function
REQ-016 States and codes: IDLE=0, BLOCK=1, CLOSE=2, GAP=3, DONE=4, FAIL=5; codes 6-7 SHALL recover to IDLE on the next clk.
REQ-017 All outputs SHALL be registered; pwm_block=1 in every state except IDLE; byp_con=1 in CLOSE, DONE and FAIL only; byp_fail=1 in FAIL only.
REQ-018 Fiber timer: 16-bit, counts time_1us ticks while fiber_err=1; clears on fiber_err=0 or reset_unit=1; saturates at FIBER_DLY_US.
REQ-019 fiber_trig SHALL be 1 while the fiber timer equals FIBER_DLY_US.
REQ-020 IDLE trigger priority, evaluated each clk: unit_fault (src 11) > fiber_trig (src 10) > byp_cmd_rx with fiber_err=0 (src 01).
REQ-021 Any IDLE trigger SHALL move to BLOCK on the next clk and latch byp_src.
REQ-022 byp_ok=1 in IDLE with no trigger SHALL go directly to DONE with byp_src=00.
REQ-023 BLOCK SHALL count GATE_OFF_US ticks, then enter CLOSE; triggers and reset_unit SHALL be ignored.
REQ-024 CLOSE: byp_ok=1 SHALL go to DONE on the next clk.
REQ-025 CLOSE: reaching CONFIRM_US ticks without byp_ok SHALL go to GAP if retry_cnt<MAX_RETRY (retry_cnt+1), else to FAIL.
REQ-026 GAP: byp_ok=1 SHALL go to DONE; reaching RETRY_GAP_US ticks SHALL return to CLOSE with the tick counter cleared.
REQ-027 The tick counter SHALL clear on every state change.
REQ-028 DONE SHALL be terminal except that byp_ok=0 for 1000 consecutive ticks goes to FAIL.
REQ-029 FAIL SHALL be terminal; byp_con stays 1; byp_ok returning to 1 SHALL NOT leave FAIL.
REQ-030 reset_unit SHALL NOT leave DONE or FAIL; only rst_n exits them (the bypass is mechanical and latching).
REQ-031 A tick coinciding with a state change SHALL count in the new state.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state IDLE, all counters 0, retry_cnt 0, and pwm_block=byp_con=byp_fail=0, byp_src=00, byp_state=0.
REQ-033 rst_n=0 mid-sequence (e.g. in CLOSE) SHALL drop byp_con immediately without waiting for clk.

Verification (FIBER_DLY_US=10, GATE_OFF_US=3, CONFIRM_US=20, RETRY_GAP_US=5, MAX_RETRY=2, tick every 40 clk)
REQ-034 Raise byp_cmd_rx -> BLOCK next clk, pwm_block=1; byp_con=1 after 3 ticks; byp_ok at tick 8 of CLOSE -> DONE, byp_src=01.
REQ-035 Hold fiber_err for 9 ticks, drop for 1, hold for 10 -> no trigger after 9; BLOCK after 10 continuous ticks, byp_src=10.
REQ-036 unit_fault, fiber_trig and byp_cmd_rx all rising on the same clk -> byp_src=11.
REQ-037 byp_ok never asserted -> CLOSE 20 / GAP 5 / CLOSE 20 / GAP 5 / CLOSE 20, then FAIL with byp_fail=1 and byp_con=1; reset_unit has no effect.
REQ-038 In DONE drop byp_ok for 999 ticks -> stays DONE; drop for 1000 ticks -> FAIL.
REQ-039 Assert rst_n=0 in CLOSE -> byp_con=0 asynchronously; after release, state=IDLE.
